// File: rtl/grid_io_side_cfg_if.sv
// Pad-ring, fabric and configuration-chain signals of one perimeter I/O tile.
// The master drives the chain, the pad inputs and the fabric data; the slave is the tile.
interface grid_io_side_cfg_if #(
  parameter int NUM_IO = 4
);
  logic              isol_n;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_commit;
  logic              ccff_tail;
  logic              cfg_valid;
  logic [NUM_IO-1:0] gfpga_pad_io_soc_in;
  logic [NUM_IO-1:0] gfpga_pad_io_soc_out;
  logic [NUM_IO-1:0] gfpga_pad_io_soc_dir;
  logic [NUM_IO-1:0] outpad;
  logic [NUM_IO-1:0] inpad;

  modport master (
    output isol_n, ccff_head, ccff_shift_en, ccff_commit, gfpga_pad_io_soc_in, outpad,
    input  ccff_tail, cfg_valid, gfpga_pad_io_soc_out, gfpga_pad_io_soc_dir, inpad
  );

  modport slave (
    input  isol_n, ccff_head, ccff_shift_en, ccff_commit, gfpga_pad_io_soc_in, outpad,
    output ccff_tail, cfg_valid, gfpga_pad_io_soc_out, gfpga_pad_io_soc_dir, inpad
  );
endinterface

// File: rtl/grid_io_side_cfg.sv
// Perimeter I/O tile: serial config chain with a committed shadow copy driving
// NUM_IO pads, each with optional input sync pipeline and optional output flop.
module grid_io_side_cfg #(
  parameter int NUM_IO      = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                 prog_clk,
  input logic                 prog_reset,
  grid_io_side_cfg_if.slave   bus
);
  localparam int L = 3 * NUM_IO;

  logic [L-1:0]      chain;
  logic [L-1:0]      shadow;
  logic              cfg_valid_q;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] out_q;

  logic [NUM_IO-1:0] dir;
  logic [NUM_IO-1:0] pad_out;
  logic [NUM_IO-1:0] pad_in;
  logic              safe;

  // Shadow samples the pre-shift chain, so a commit during a shift sees the old contents.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      chain       <= '0;
      shadow      <= '0;
      cfg_valid_q <= 1'b0;
    end else begin
      if (bus.ccff_shift_en) chain <= {chain[L-2:0], bus.ccff_head};
      if (bus.ccff_commit) begin
        shadow      <= chain;
        cfg_valid_q <= 1'b1;
      end
    end
  end

  // Datapath flops run regardless of select bits so mode switches need no flush.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      out_q <= '0;
    end else begin
      sync_q[0] <= bus.gfpga_pad_io_soc_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      out_q <= bus.outpad;
    end
  end

  always_comb begin
    dir     = '0;
    pad_out = '0;
    pad_in  = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      dir[i]     = shadow[3*i];
      pad_in[i]  = shadow[3*i+1] ? sync_q[SYNC_STAGES-1][i] : bus.gfpga_pad_io_soc_in[i];
      pad_out[i] = shadow[3*i] & (shadow[3*i+2] ? out_q[i] : bus.outpad[i]);
    end
  end

  // Safe-state gating sits after every flop so isolation acts without a clock.
  assign safe = !cfg_valid_q || !bus.isol_n;

  assign bus.gfpga_pad_io_soc_dir = safe ? '0 : dir;
  assign bus.gfpga_pad_io_soc_out = safe ? '0 : pad_out;
  assign bus.inpad                = safe ? '0 : pad_in;
  assign bus.ccff_tail            = chain[L-1];
  assign bus.cfg_valid            = cfg_valid_q;
endmodule

// File: doc/grid_io_side_cfg.md
# grid_io_side_cfg

Parametrised I/O grid tile with NUM_IO pad subtiles. Each subtile has its own 3-bit configuration word that selects direction, input registering and output registering. Configuration arrives on a gated ccff shift chain and only takes effect when committed into a shadow register, so a tile can be reprogrammed without glitching the pads. The block sits on the fabric perimeter between the SoC pad ring (gfpga_pad_io_soc_*) and the adjacent routing channel.

## Interface
- NUM_IO, default 4: number of pad subtiles; chain length L = 3*NUM_IO.
- SYNC_STAGES, default 2, must be ≥1: flop depth of the registered input path.
- prog_clk  in  1  single clock for the chain, the shadow register and all datapath flops.
- prog_reset  in  1  asynchronous, active-low reset.
- isol_n  in  1  active-low isolation; takes effect combinationally.
- ccff_head  in  1  serial configuration input.
- ccff_shift_en  in  1  when 1, the chain shifts one position this cycle.
- ccff_commit  in  1  single-cycle strobe that copies the chain into the active config.
- ccff_tail  out  1  serial configuration output; equals chain[L-1].
- cfg_valid  out  1  high once at least one commit has occurred since reset.
- gfpga_pad_io_soc_in  in  NUM_IO  pad-to-core data.
- gfpga_pad_io_soc_out  out  NUM_IO  core-to-pad data.
- gfpga_pad_io_soc_dir  out  NUM_IO  1 = pad driven as output.
- outpad  in  NUM_IO  fabric data toward the pad.
- inpad  out  NUM_IO  pad data toward the fabric.

## Operation
- Chain: an L-bit register.
  - When shift_en=1: chain[0] <= ccff_head and chain[k] <= chain[k-1].
  - When shift_en=0: the chain holds.
- Active config: an L-bit shadow register, loaded from the chain on the cycle commit=1.
- Commit and shift in the same cycle: the shadow captures the pre-shift chain value, and the chain still shifts.
- Per-pad word for pad i, taken from the active config:
  - bit 3i = dir
  - bit 3i+1 = in_reg
  - bit 3i+2 = out_reg
- Shift order: the first bit shifted in ends in chain[L-1], which is out_reg of pad NUM_IO-1. The last bit shifted in ends in chain[0], which is dir of pad 0.
- Input path:
  - in_reg=0: inpad[i] = soc_in[i], combinational.
  - in_reg=1: inpad[i] is the output of a SYNC_STAGES flop pipeline fed by soc_in[i].
- Output path:
  - out_reg=0: soc_out[i] = outpad[i].
  - out_reg=1: soc_out[i] = outpad[i] registered by one flop.
  - In both cases soc_out[i] is forced to 0 when dir=0.
- soc_dir[i] = dir.
- The sync pipelines and output flops run continuously, whatever their select bit.
- Safe state applies when cfg_valid=0 or isol_n=0:
  - soc_dir=0, soc_out=0 and inpad=0 for all pads.
  - The safe-state gating is combinational and sits after all flops.
  - Internal flops keep updating during the safe state.
- cfg_valid is set on the cycle after the first commit. It is cleared only by reset.
- Reset (prog_reset=0) asynchronously clears the chain, the shadow, all sync and output flops, and cfg_valid. Every output then reads 0.
- Reset asserted mid-shift: the partially loaded chain is discarded. After release the chain holds all zeros.

## Timing
- ccff_tail tracks chain[L-1]. A bit presented at ccff_head appears on ccff_tail after L shift-enabled edges.
- Commit to pad effect: the new config drives the pads starting the cycle after the commit edge. cfg_valid rises on that same edge.
- Registered input latency is SYNC_STAGES edges from soc_in to inpad. Combinational input latency is 0.
- Registered output latency is 1 edge from outpad to soc_out.
- When in_reg or out_reg toggles, the output switches immediately to the already-running flop value. No flush is needed.
- isol_n assertion and deassertion take effect in the same cycle, with no clock dependency.
- Release of prog_reset is assumed synchronised externally. The first functional edge is the first prog_clk edge after release.

## Test plan
All scenarios use NUM_IO=4 (L=12) and SYNC_STAGES=2.
- **Reset:** prog_reset=0 with random inputs -> all outputs 0 and cfg_valid=0. Shift 12 ones, reset mid-way at bit 6, release, shift 12 zeros -> ccff_tail stays 0.
- **Chain pass-through:** shift the pattern 101100111000 with commit held at 0 -> ccff_tail reproduces the pattern starting at the 12th edge, and soc_dir stays 0000.
- **Commit and combinational path:** load dir=1, in_reg=0, out_reg=0 on all pads, then commit.
  - The cycle after commit: cfg_valid=1 and soc_dir=1111.
  - outpad=1010 -> soc_out=1010 in the same cycle.
- **Registered paths:** pad 0 with in_reg=1 and dir=0; pad 3 with out_reg=1 and dir=1.
  - soc_in[0] steps 0->1 -> inpad[0]=1 after exactly 2 edges.
  - outpad[3] steps 0->1 -> soc_out[3]=1 after 1 edge.
- **Simultaneous commit and shift:** commit while shifting -> the active config equals the chain value before that edge, and the next shifted bit does not alter the pads.
- **Isolation:** with a valid config, isol_n=0 -> soc_dir=0000, soc_out=0000 and inpad=0000 in the same cycle. Set isol_n=1 -> the prior values return immediately, and the registered input shows its current pipeline value.
